// File: rtl/bnn_exec_unit.sv
// Multi-cycle XNOR-popcount execute unit for the custom BNN opcode.
// Optional feature macro: BNN_SIGNED_DOT_EN (signed +/-1 dot product result).
module bnn_exec_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_E,
    input  logic             en_threshold_E,
    input  logic             ms_WE_E,
    input  logic             at_WE_E,
    input  logic [XLEN-1:0]  srcA_E,
    input  logic [XLEN-1:0]  srcB_E,
    input  logic [XLEN-1:0]  imm_E,
    output logic             busy_E,
    output logic             result_valid_E,
    output logic [XLEN-1:0]  result_E,
    output logic [CNT_W-1:0] ms_q,
    output logic [CNT_W-1:0] at_q
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   xv;
    logic [XLEN-1:0]   mask;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  k_s;
    logic [CNT_W-1:0]  k_new;
    logic [CNT_W-1:0]  pc;
    logic [CNT_W-1:0]  acc_next;
    logic [CNT_W-1:0]  fin_cnt;
    logic [CNT_W-1:0]  ms_wr;
    logic [CHUNK-1:0]  chunk;
    logic              thr_s;
    logic              fin_thr;
    logic              ge;
    logic              in_run;
    logic [XLEN-1:0]   fin_res;

    assign in_run = (state == RUN);
    assign busy_E = (start_E & ~in_run) | in_run;

    // MS=XLEN would overflow the shift, so it gets an explicit all-ones mask
    assign mask = (ms_q >= CNT_W'(XLEN)) ? '1
                : ((XLEN'(1) << ms_q) - XLEN'(1));
    assign k_new = CNT_W'((int'(ms_q) + CHUNK - 1) / CHUNK);
    assign ms_wr = (imm_E > XLEN'(XLEN)) ? CNT_W'(XLEN)
                 : imm_E[CNT_W-1:0];

    assign chunk = xv[int'(idx)*CHUNK +: CHUNK];

    always_comb begin
        pc = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pc = pc + CNT_W'(chunk[i]);
        end
    end

    assign acc_next = acc + pc;
    assign fin_cnt  = in_run ? acc_next : '0;
    assign fin_thr  = in_run ? thr_s : en_threshold_E;
    assign ge       = (fin_cnt >= at_q);

`ifdef BNN_SIGNED_DOT_EN
    logic [CNT_W-1:0] ms_s;
    logic [CNT_W-1:0] fin_ms;
    logic [CNT_W+1:0] dot;

    assign fin_ms = in_run ? ms_s : ms_q;
    assign dot    = {1'b0, fin_cnt, 1'b0} - {2'b00, fin_ms};

    always_comb begin
        fin_res = '0;
        if (fin_thr) begin
            fin_res = {{(XLEN-1){1'b0}}, ge};
        end else begin
            fin_res = {{(XLEN-CNT_W-2){dot[CNT_W+1]}}, dot};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_s <= '0;
        end else if (start_E && !in_run) begin
            ms_s <= ms_q;
        end
    end
`else
    always_comb begin
        fin_res = '0;
        if (fin_thr) begin
            fin_res = {{(XLEN-1){1'b0}}, ge};
        end else begin
            fin_res = {{(XLEN-CNT_W){1'b0}}, fin_cnt};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            result_valid_E <= 1'b0;
            result_E       <= '0;
            ms_q           <= CNT_W'(XLEN);
            at_q           <= '0;
            acc            <= '0;
            idx            <= '0;
            k_s            <= '0;
            xv             <= '0;
            thr_s          <= 1'b0;
        end else begin
            if (ms_WE_E) ms_q <= ms_wr;
            if (at_WE_E) at_q <= imm_E[CNT_W-1:0];
            result_valid_E <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start_E) begin
                        xv    <= ~(srcA_E ^ srcB_E) & mask;
                        thr_s <= en_threshold_E;
                        k_s   <= k_new;
                        idx   <= '0;
                        acc   <= '0;
                        if (k_new == '0) begin
                            state          <= DONE;
                            result_E       <= fin_res;
                            result_valid_E <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == k_s - 1'b1) begin
                        state          <= DONE;
                        result_E       <= fin_res;
                        result_valid_E <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_exec_unit.sv
// Directed bench for bnn_exec_unit: latency, results, config regs, reset.
module tb_bnn_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_E;
    logic        en_threshold_E;
    logic        ms_WE_E;
    logic        at_WE_E;
    logic [31:0] srcA_E;
    logic [31:0] srcB_E;
    logic [31:0] imm_E;
    logic        busy_E;
    logic        result_valid_E;
    logic [31:0] result_E;
    logic [5:0]  ms_q;
    logic [5:0]  at_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bnn_exec_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start_E        (start_E),
        .en_threshold_E (en_threshold_E),
        .ms_WE_E        (ms_WE_E),
        .at_WE_E        (at_WE_E),
        .srcA_E         (srcA_E),
        .srcB_E         (srcB_E),
        .imm_E          (imm_E),
        .busy_E         (busy_E),
        .result_valid_E (result_valid_E),
        .result_E       (result_E),
        .ms_q           (ms_q),
        .at_q           (at_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_ms(input logic [31:0] v);
        @(negedge clk);
        ms_WE_E = 1'b1;
        imm_E   = v;
        @(posedge clk);
        #1 ms_WE_E = 1'b0;
    endtask

    task automatic wr_at(input logic [31:0] v);
        @(negedge clk);
        at_WE_E = 1'b1;
        imm_E   = v;
        @(posedge clk);
        #1 at_WE_E = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic thr,
                          input int k, input logic [31:0] exp,
                          input logic mw, input logic [31:0] im);
        int cyc;
        int nbusy;
        cyc   = 0;
        nbusy = 0;
        @(negedge clk);
        srcA_E         = a;
        srcB_E         = b;
        en_threshold_E = thr;
        start_E        = 1'b1;
        ms_WE_E        = mw;
        imm_E          = im;
        #1 chk({tag, "_busy_start"}, {31'b0, busy_E}, 32'd1);
        @(posedge clk);
        #1;
        start_E = 1'b0;
        ms_WE_E = 1'b0;
        srcA_E  = ~a;
        srcB_E  = b ^ 32'h5A5A_5A5A;
        en_threshold_E = ~thr;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (result_valid_E) begin
                cyc = c;
                break;
            end
            if (busy_E) nbusy++;
        end
        chk({tag, "_latency"}, cyc, k + 1);
        chk({tag, "_busy_cycles"}, nbusy, k);
        chk({tag, "_busy_done"}, {31'b0, busy_E}, 32'd0);
        chk({tag, "_result"}, result_E, exp);
        @(negedge clk);
        chk({tag, "_valid_drop"}, {31'b0, result_valid_E}, 32'd0);
        chk({tag, "_held"}, result_E, exp);
    endtask

    initial begin
        reset          = 1'b1;
        start_E        = 1'b0;
        en_threshold_E = 1'b0;
        ms_WE_E        = 1'b0;
        at_WE_E        = 1'b0;
        srcA_E         = '0;
        srcB_E         = '0;
        imm_E          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy_E}, 32'd0);
        chk("rst_valid", {31'b0, result_valid_E}, 32'd0);
        chk("rst_result", result_E, 32'd0);
        chk("rst_ms", {26'b0, ms_q}, 32'd32);
        chk("rst_at", {26'b0, at_q}, 32'd0);

        run_op("full_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4,
               32'd32, 1'b0, 32'd0);

        wr_ms(32'd12);
        #1 chk("ms_12", {26'b0, ms_q}, 32'd12);
`ifdef BNN_SIGNED_DOT_EN
        run_op("ms12", 32'h0000_0FFF, 32'h0000_0F0F, 1'b0, 2,
               32'd4, 1'b0, 32'd0);
`else
        run_op("ms12", 32'h0000_0FFF, 32'h0000_0F0F, 1'b0, 2,
               32'd8, 1'b0, 32'd0);
`endif

        wr_at(32'd5);
        #1 chk("at_5", {26'b0, at_q}, 32'd5);
        run_op("thr_at5", 32'h0000_0FFF, 32'h0000_0F0F, 1'b1, 2,
               32'd1, 1'b0, 32'd0);
        wr_at(32'd9);
        run_op("thr_at9", 32'h0000_0FFF, 32'h0000_0F0F, 1'b1, 2,
               32'd0, 1'b0, 32'd0);

        wr_ms(32'd40);
        #1 chk("ms_clamp", {26'b0, ms_q}, 32'd32);
`ifdef BNN_SIGNED_DOT_EN
        run_op("anti", 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 4,
               32'hFFFF_FFE0, 1'b0, 32'd0);
`else
        run_op("anti", 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 4,
               32'd0, 1'b0, 32'd0);
`endif

        wr_ms(32'd0);
        #1 chk("ms_0", {26'b0, ms_q}, 32'd0);
        run_op("ms0", 32'h1234_5678, 32'h8765_4321, 1'b0, 0,
               32'd0, 1'b0, 32'd0);
        wr_at(32'd0);
        run_op("ms0_at0", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0,
               32'd1, 1'b0, 32'd0);

        wr_ms(32'd12);
        @(negedge clk);
        srcA_E  = 32'h0000_0FFF;
        srcB_E  = 32'h0000_0F0F;
        en_threshold_E = 1'b0;
        start_E = 1'b1;
        @(posedge clk);
        #1 start_E = 1'b0;
        @(negedge clk);
        chk("mid_run1_busy", {31'b0, busy_E}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'b0, busy_E}, 32'd0);
        chk("mid_rst_valid", {31'b0, result_valid_E}, 32'd0);
        chk("mid_rst_result", result_E, 32'd0);
        chk("mid_rst_ms", {26'b0, ms_q}, 32'd32);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_valid", {31'b0, result_valid_E}, 32'd0);
        end

        wr_ms(32'd12);
`ifdef BNN_SIGNED_DOT_EN
        run_op("ms_we_start", 32'h0000_0FFF, 32'h0000_0F0F, 1'b0, 2,
               32'd4, 1'b1, 32'd40);
`else
        run_op("ms_we_start", 32'h0000_0FFF, 32'h0000_0F0F, 1'b0, 2,
               32'd8, 1'b1, 32'd40);
`endif
        chk("ms_we_after", {26'b0, ms_q}, 32'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
